ctrl_seq: RTL and testbench

- Registered, handshaked decode/control stage for the 5-bit-opcode processor. It replaces the purely combinational decoder in the pipelined design.
- Decodes the opcode into the existing control-signal set and holds the result in an output register, or in a 2-entry skid buffer when configured.
- Sequences processor-state instructions: HALT, SIIC, RTI and illegal opcodes.
- Sits between fetch (upstream valid/ready) and execute (downstream valid/ready).

---
 rtl/ctrl_seq_if.sv | 50 +++++
 rtl/ctrl_seq.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: fetch-side and execute-side handshake plus control bundle.
interface ctrl_seq_if #(
  parameter int PCW = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [4:0]     in_op;
  logic [PCW-1:0] in_pc;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [PCW-1:0] out_pc;
  logic           reg_write;
  logic           val2reg;
  logic           link;
  logic           lbi;
  logic           alu_sel;
  logic           mem_en;
  logic           mem_wr;
  logic           reg_jmp;
  logic           b_flag;
  logic           j_flag;
  logic           valid_n;
  logic [1:0]     dest_sel;
  logic [2:0]     imm_sel;
  logic [4:0]     alu_op;
  logic           redirect_valid;
  logic [PCW-1:0] redirect_pc;
  logic [PCW-1:0] epc;
  logic           halted;
  logic           err;

  modport master (
    output in_valid, in_op, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc,
    input  reg_write, val2reg, link, lbi, alu_sel,
    input  mem_en, mem_wr, reg_jmp, b_flag, j_flag,
    input  valid_n, dest_sel, imm_sel, alu_op,
    input  redirect_valid, redirect_pc, epc, halted, err
  );

  modport slave (
    input  in_valid, in_op, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc,
    output reg_write, val2reg, link, lbi, alu_sel,
    output mem_en, mem_wr, reg_jmp, b_flag, j_flag,
    output valid_n, dest_sel, imm_sel, alu_op,
    output redirect_valid, redirect_pc, epc, halted, err
  );
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: registered decode/control stage with HALT/SIIC/RTI sequencing.
// Bundle held in one output register (SKID=0) or a 2-entry skid buffer.
module ctrl_seq #(
  parameter int PCW = 16,
  parameter logic [PCW-1:0] EXC_VEC = PCW'(16'h0002),
  parameter int SKID = 0,
  parameter int ILLEGAL_HALT = 1
) (
  input logic clk,
  input logic rst_n,
  ctrl_seq_if.slave bus
);

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_SIIC = 5'b00010;
  localparam logic [4:0] OP_RTI  = 5'b00011;

  typedef enum logic [1:0] {RUN, HALT, TRAP} state_t;

  typedef struct packed {
    logic           reg_write;
    logic           val2reg;
    logic           link;
    logic           lbi;
    logic           alu_sel;
    logic           mem_en;
    logic           mem_wr;
    logic           reg_jmp;
    logic           b_flag;
    logic           j_flag;
    logic           valid_n;
    logic [1:0]     dest_sel;
    logic [2:0]     imm_sel;
    logic [4:0]     alu_op;
    logic [PCW-1:0] pc;
  } ctl_t;

  function automatic ctl_t decode(
    input logic [4:0]     op,
    input logic [PCW-1:0] pc
  );
    ctl_t c;
    c = '0;
    c.alu_op = (op == OP_RTI) ? 5'b00001 : op;
    c.pc = pc;
    unique case (1'b1)
      op[4:2] == 3'b000: begin
        c.alu_sel = 1'b1;
        c.dest_sel = 2'b11;
        c.imm_sel = 3'b100;
      end
      op[4:2] == 3'b010, op[4:2] == 3'b101: begin
        c.reg_write = 1'b1;
        c.alu_sel = 1'b1;
        c.dest_sel = 2'b11;
        c.valid_n = 1'b1;
        c.imm_sel = op[1] ? 3'b000 : 3'b100;
      end
      op[4:1] == 4'b1000: begin
        c.alu_sel = 1'b1;
        c.dest_sel = 2'b11;
        c.imm_sel = 3'b100;
        c.mem_en = 1'b1;
        c.valid_n = 1'b1;
        c.mem_wr = !op[0];
        c.val2reg = op[0];
        c.reg_write = op[0];
      end
      op == 5'b10011: begin
        c.alu_sel = 1'b1;
        c.imm_sel = 3'b100;
        c.reg_write = 1'b1;
        c.mem_en = 1'b1;
        c.mem_wr = 1'b1;
        c.valid_n = 1'b1;
      end
      op == 5'b11001, op[4:1] == 4'b1101,
      op[4:2] == 3'b111: begin
        c.dest_sel = 2'b01;
        c.reg_write = 1'b1;
        c.valid_n = 1'b1;
      end
      op[4:2] == 3'b011: begin
        c.imm_sel = 3'b101;
        c.valid_n = 1'b1;
      end
      op == 5'b11000: begin
        c.alu_sel = 1'b1;
        c.reg_write = 1'b1;
        c.lbi = 1'b1;
        c.imm_sel = 3'b101;
        c.valid_n = 1'b1;
      end
      op == 5'b10010: begin
        c.alu_sel = 1'b1;
        c.reg_write = 1'b1;
        c.imm_sel = 3'b001;
        c.valid_n = 1'b1;
      end
      op[4:2] == 3'b001 && !op[0]: begin
        c.alu_sel = 1'b1;
        c.dest_sel = 2'b10;
        c.j_flag = 1'b1;
        c.b_flag = 1'b1;
        c.imm_sel = 3'b110;
        c.link = op[1];
        c.reg_write = op[1];
        c.valid_n = op[1];
      end
      op[4:2] == 3'b001 && op[0]: begin
        c.alu_sel = 1'b1;
        c.dest_sel = 2'b10;
        c.reg_jmp = 1'b1;
        c.imm_sel = 3'b101;
        c.b_flag = !op[1];
        c.link = op[1];
        c.reg_write = op[1];
        c.valid_n = op[1];
      end
      default: ;
    endcase
    return c;
  endfunction

  state_t         state, state_nx;
  logic           rti_pend, rti_nx;
  logic [PCW-1:0] epc, epc_nx;
  logic           err, err_nx;
  logic           illegal;
  logic           run_ok;
  logic           in_ready;
  logic           take;
  logic           ov;
  ctl_t           ob;
  ctl_t           dec;

  // X/Z opcodes only exist in simulation; synthesis sees a constant 0.
  always_comb begin
    illegal = 1'b0;
`ifndef SYNTHESIS
    illegal = $isunknown(bus.in_op);
`endif
  end

  assign run_ok = (state == RUN) && !rti_pend;
  assign take = bus.in_valid && in_ready && !bus.flush;
  assign dec = decode(bus.in_op, bus.in_pc);

  always_comb begin
    state_nx = state;
    rti_nx = 1'b0;
    epc_nx = epc;
    err_nx = err;
    unique case (state)
      RUN: begin
        if (take) begin
          if (illegal) begin
            err_nx = 1'b1;
            if (ILLEGAL_HALT != 0) begin
              state_nx = HALT;
            end else begin
              state_nx = TRAP;
              epc_nx = bus.in_pc + PCW'(2);
            end
          end else if (bus.in_op == OP_HALT) begin
            state_nx = HALT;
          end else if (bus.in_op == OP_SIIC) begin
            state_nx = TRAP;
            epc_nx = bus.in_pc + PCW'(2);
          end else if (bus.in_op == OP_RTI) begin
            rti_nx = 1'b1;
          end
        end
      end
      HALT: state_nx = HALT;
      TRAP: state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rti_pend <= 1'b0;
      epc <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      rti_pend <= rti_nx;
      epc <= epc_nx;
      err <= err_nx;
    end
  end

  generate
    if (SKID == 0) begin : g_reg
      assign in_ready = run_ok && (!ov || bus.out_ready);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov <= 1'b0;
          ob <= '0;
        end else if (bus.flush) begin
          ov <= 1'b0;
        end else if (take) begin
          ov <= 1'b1;
          ob <= dec;
        end else if (bus.out_ready) begin
          ov <= 1'b0;
        end
      end
    end else begin : g_skid
      logic sv;
      ctl_t sb;

      // in_ready depends only on registered state, never on out_ready.
      assign in_ready = run_ok && !sv;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov <= 1'b0;
          ob <= '0;
          sv <= 1'b0;
          sb <= '0;
        end else if (bus.flush) begin
          ov <= 1'b0;
          sv <= 1'b0;
        end else if (sv) begin
          if (!ov || bus.out_ready) begin
            ob <= sb;
            ov <= 1'b1;
            sv <= 1'b0;
          end
        end else if (take) begin
          if (!ov || bus.out_ready) begin
            ob <= dec;
            ov <= 1'b1;
          end else begin
            sb <= dec;
            sv <= 1'b1;
          end
        end else if (bus.out_ready) begin
          ov <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.in_ready = in_ready;
  assign bus.out_valid = ov;
  assign bus.out_pc = ob.pc;
  assign bus.reg_write = ob.reg_write;
  assign bus.val2reg = ob.val2reg;
  assign bus.link = ob.link;
  assign bus.lbi = ob.lbi;
  assign bus.alu_sel = ob.alu_sel;
  assign bus.mem_en = ob.mem_en;
  assign bus.mem_wr = ob.mem_wr;
  assign bus.reg_jmp = ob.reg_jmp;
  assign bus.b_flag = ob.b_flag;
  assign bus.j_flag = ob.j_flag;
  assign bus.valid_n = ob.valid_n;
  assign bus.dest_sel = ob.dest_sel;
  assign bus.imm_sel = ob.imm_sel;
  assign bus.alu_op = ob.alu_op;

  assign bus.redirect_valid = (state == TRAP) || rti_pend;
  assign bus.redirect_pc = (state == TRAP) ? EXC_VEC :
                           rti_pend ? epc : '0;
  assign bus.epc = epc;
  assign bus.halted = (state == HALT);
  assign bus.err = err;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: scoreboard bench for ctrl_seq, run on SKID=0 then SKID=1.
module tb_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_op = '0;
  logic [15:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [36:0] q[$];

  always #5 clk = ~clk;

  ctrl_seq_if #(.PCW(16)) i0 ();
  ctrl_seq_if #(.PCW(16)) i1 ();

  assign i0.in_valid = in_valid && !sel;
  assign i1.in_valid = in_valid && sel;
  assign i0.in_op = in_op;
  assign i1.in_op = in_op;
  assign i0.in_pc = in_pc;
  assign i1.in_pc = in_pc;
  assign i0.flush = flush;
  assign i1.flush = flush;
  assign i0.out_ready = out_ready;
  assign i1.out_ready = out_ready;

  ctrl_seq #(.SKID(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  ctrl_seq #(.SKID(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  logic [36:0] b0, b1, obs;
  logic        ov, rdy, rv, halted, err;
  logic [15:0] rpc, epc;

  assign b0 = {i0.reg_write, i0.val2reg, i0.link, i0.lbi,
               i0.alu_sel, i0.mem_en, i0.mem_wr, i0.reg_jmp,
               i0.b_flag, i0.j_flag, i0.valid_n, i0.dest_sel,
               i0.imm_sel, i0.alu_op, i0.out_pc};
  assign b1 = {i1.reg_write, i1.val2reg, i1.link, i1.lbi,
               i1.alu_sel, i1.mem_en, i1.mem_wr, i1.reg_jmp,
               i1.b_flag, i1.j_flag, i1.valid_n, i1.dest_sel,
               i1.imm_sel, i1.alu_op, i1.out_pc};
  assign obs = sel ? b1 : b0;
  assign ov = sel ? i1.out_valid : i0.out_valid;
  assign rdy = sel ? i1.in_ready : i0.in_ready;
  assign rv = sel ? i1.redirect_valid : i0.redirect_valid;
  assign rpc = sel ? i1.redirect_pc : i0.redirect_pc;
  assign epc = sel ? i1.epc : i0.epc;
  assign halted = sel ? i1.halted : i0.halted;
  assign err = sel ? i1.err : i0.err;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s skid=%0d got=%0h exp=%0h", tag, sel, got, exp);
    end
  endtask

  // {rw,v2r,link,lbi,alu,men,mwr,rjmp,b,j,vn}, dest, imm, alu_op, pc
  function automatic logic [36:0] exp_bundle(input logic [4:0] op,
                                             input logic [15:0] pc);
    logic [15:0] c;
    casez (op)
      5'b000??: c = {11'b00001000000, 2'b11, 3'b100};
      5'b00100: c = {11'b00001000110, 2'b10, 3'b110};
      5'b00101: c = {11'b00001001100, 2'b10, 3'b101};
      5'b00110: c = {11'b10101000111, 2'b10, 3'b110};
      5'b00111: c = {11'b10101001001, 2'b10, 3'b101};
      5'b0100?, 5'b1010?: c = {11'b10001000001, 2'b11, 3'b100};
      5'b0101?, 5'b1011?: c = {11'b10001000001, 2'b11, 3'b000};
      5'b011??: c = {11'b00000000001, 2'b00, 3'b101};
      5'b10000: c = {11'b00001110001, 2'b11, 3'b100};
      5'b10001: c = {11'b11001100001, 2'b11, 3'b100};
      5'b10010: c = {11'b10001000001, 2'b00, 3'b001};
      5'b10011: c = {11'b10001110001, 2'b00, 3'b100};
      5'b11000: c = {11'b10011000001, 2'b00, 3'b101};
      default:  c = {11'b10000000001, 2'b01, 3'b000};
    endcase
    return {c, (op == 5'b00011) ? 5'b00001 : op, pc};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (ov) begin
        if (q.size() == 0) begin
          check("sb_underflow", ov, 0);
        end else begin
          check(out_ready ? "retire" : "hold", obs, q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (flush) q.delete();
      else if (in_valid && rdy) q.push_back(exp_bundle(in_op, in_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (rdy) done = 1'b1;
      step();
    end
    if (!done) check(tag, rdy, 1);
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [15:0] pc);
    in_valid = 1'b1;
    in_op = op;
    in_pc = pc;
    wait_accept("accept_timeout");
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ov"}, ov, 0);
    check({tag, "_bundle"}, obs, 0);
    check({tag, "_rv"}, rv, 0);
    check({tag, "_rpc"}, rpc, 0);
    check({tag, "_epc"}, epc, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic run_all();
    bit pend, acc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    in_op = '0;
    in_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    step();
    rst_n = 1'b1;

    issue(5'b11011, 16'h0010);
    @(negedge clk);
    check("add_valid", ov, 1);
    check("add_alu_op", obs[20:16], 5'b11011);
    check("add_dest", obs[25:24], 2'b01);
    check("add_rw_vn", {obs[36], obs[26]}, 2'b11);
    step();

    for (int op = 1; op < 32; op++)
      if (op != 2 && op != 3) issue(5'(op), 16'(256 + 2 * op));
    repeat (2) step();

    out_ready = 1'b0;
    issue(5'b10001, 16'h0020);
    in_valid = 1'b1;
    in_op = 5'b10000;
    in_pc = 16'h0022;
    pend = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_rdy", rdy, (sel && k == 0));
      check("stall_ld", {ov, obs[35], obs[31]}, 3'b111);
      acc = pend && rdy;
      step();
      if (acc) begin
        in_valid = 1'b0;
        pend = 1'b0;
      end
    end
    out_ready = 1'b1;
    if (pend) wait_accept("st_timeout");
    repeat (3) step();

    issue(5'b00010, 16'h0040);
    @(negedge clk);
    check("siic_rv", rv, 1);
    check("siic_rpc", rpc, 16'h0002);
    check("siic_epc", epc, 16'h0042);
    check("siic_rdy", rdy, 0);
    step();
    @(negedge clk);
    check("siic_rv_end", rv, 0);
    check("siic_rdy_end", rdy, 1);
    step();
    issue(5'b01000, 16'h0044);
    issue(5'b00011, 16'h0046);
    @(negedge clk);
    check("rti_rv", rv, 1);
    check("rti_rpc", rpc, 16'h0042);
    check("rti_rdy", rdy, 0);
    check("rti_alu_op", obs[20:16], 5'b00001);
    step();
    @(negedge clk);
    check("rti_rv_end", rv, 0);
    check("rti_rdy_end", rdy, 1);
    step();

    in_valid = 1'b1;
    in_op = 5'b00010;
    in_pc = 16'h0080;
    flush = 1'b1;
    @(negedge clk);
    check("fc_rdy", rdy, 1);
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("fc_ov", ov, 0);
    check("fc_epc", epc, 16'h0042);
    check("fc_rv", rv, 0);
    check("fc_rdy", rdy, 1);
    step();
    @(negedge clk);
    check("fc_rv2", rv, 0);
    step();

    out_ready = 1'b0;
    issue(5'b11100, 16'h0084);
    flush = 1'b1;
    @(negedge clk);
    check("fh_held", ov, 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("fh_clr", ov, 0);
    step();
    out_ready = 1'b1;

    out_ready = 1'b0;
    issue(5'b00000, 16'h0090);
    in_valid = 1'b1;
    in_op = 5'b11011;
    in_pc = 16'h0092;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("halt_rdy", rdy, 0);
      if (k == 0) check("halted", halted, 1);
      step();
      if (k == 2) out_ready = 1'b1;
    end
    @(negedge clk);
    check("halt_drain", ov, 0);
    check("halt_hold", halted, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_halt");
    step();
    rst_n = 1'b1;

    out_ready = 1'b0;
    issue(5'b10001, 16'h00a0);
    @(negedge clk);
    check("rs_held", ov, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_stall");
    @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rs_no_rv", rv, 0);
      check("rs_no_ov", ov, 0);
    end
    check("sb_drain", q.size(), 0);
    step();
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      run_all();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
